// File: rtl/rotary_delta_gen_pkg.sv
// rotary_pkg: shared delta type, 8-bit clamp and quadrature step decode
package rotary_pkg;
  typedef logic signed [7:0] delta8_t;
  function automatic delta8_t sat8(input logic signed [15:0] x);
    return x > 16'sd127 ? 8'sd127 : x < -16'sd127 ? -8'sd127 : delta8_t'(x[7:0]);
  endfunction
  function automatic logic [1:0] gray_idx(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction
  function automatic logic signed [1:0] quad_step(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] d;
    d = gray_idx(cur) - gray_idx(prev);
    return d == 2'd1 ? 2'sd1 : d == 2'd3 ? -2'sd1 : 2'sd0;
  endfunction
endpackage

// File: rtl/rotary_delta_gen_quad_channel.sv
// quad_channel: synchroniser, stability filter and quadrature decode for one encoder
module quad_channel
  import rotary_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic              clk,
  input  logic              RESn,
  input  logic              a,
  input  logic              b,
  input  logic              invert,
  output logic              step_valid,
  output logic signed [1:0] step
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [SYNC_STAGES-1:0] sa, sb;
  logic [1:0] cur, nxt, filt;
  logic [CW-1:0] cnt;
  logic loaded, stable;
  logic signed [1:0] raw;
  assign cur = {sa[SYNC_STAGES-1], sb[SYNC_STAGES-1]};
  assign nxt = {sa[SYNC_STAGES-2], sb[SYNC_STAGES-2]};
  assign stable = cnt == CW'(FILTER_LEN);
  assign raw = quad_step(filt, cur);
  // cnt is how long cur has held its value; the first accepted sample only seeds filt
  always_ff @(posedge clk or negedge RESn)
    if (!RESn) begin
      sa <= '0;
      sb <= '0;
      cnt <= '0;
      filt <= '0;
      loaded <= 1'b0;
      step_valid <= 1'b0;
      step <= '0;
    end else begin
      sa <= {sa[SYNC_STAGES-2:0], a};
      sb <= {sb[SYNC_STAGES-2:0], b};
      cnt <= nxt != cur ? CW'(1) : stable ? cnt : cnt + 1'b1;
      if (stable) begin
        filt <= cur;
        loaded <= 1'b1;
      end
      step_valid <= stable && loaded && raw != 2'sd0;
      step <= invert ? -raw : raw;
    end
endmodule

// File: rtl/rotary_delta_gen.sv
// rotary_delta_gen: encoder/host deltas into saturating accumulators, strobed out as 8-bit deltas
module rotary_delta_gen
  import rotary_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int STROBE_DIV  = 4000,
  parameter int ACC_W       = 12
) (
  input  logic              clk,
  input  logic              RESn,
  input  logic [1:0]        enc_a,
  input  logic [1:0]        enc_b,
  input  logic [1:0]        invert,
  input  logic              src_sel,
  input  logic              host_valid,
  input  logic signed [8:0] host_dx,
  input  logic signed [8:0] host_dy,
  output logic              rotary_inc,
  output logic              rotary_abs,
  output delta8_t           rotary_a,
  output delta8_t           rotary_b,
  output logic [1:0]        overflow
);
  localparam int TW = $clog2(STROBE_DIV);
  localparam logic signed [ACC_W:0] LIM = (ACC_W+1)'(2**(ACC_W-1) - 1);
  logic [TW-1:0] tmr;
  logic src_q, chg, tc, fire;
  logic [1:0] nz, ovf;
  delta8_t dout [2];
  logic signed [8:0] hd [2];
  assign hd[0] = host_dx;
  assign hd[1] = host_dy;
  assign chg = src_sel != src_q;
  assign tc = tmr == TW'(STROBE_DIV - 1);
  assign fire = tc && !chg && nz != 2'b00;
  for (genvar i = 0; i < 2; i++) begin : g_ch
    logic sv, oq;
    logic signed [1:0] st;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W:0] inc, sum, sat;
    logic signed [15:0] acc16;
    delta8_t emit, dq;
    quad_channel #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_q (
      .clk(clk), .RESn(RESn), .a(enc_a[i]), .b(enc_b[i]), .invert(invert[i]),
      .step_valid(sv), .step(st)
    );
    assign acc16 = acc;
    assign emit = fire ? sat8(acc16) : '0;
    assign inc = src_sel ? (host_valid ? (ACC_W+1)'(hd[i]) : '0) : (sv ? (ACC_W+1)'(st) : '0);
    // residue plus same-cycle increment, so nothing is lost on a strobe edge
    assign sum = (ACC_W+1)'(acc) - (ACC_W+1)'(emit) + inc;
    assign sat = sum > LIM ? LIM : sum < -LIM ? -LIM : sum;
    always_ff @(posedge clk or negedge RESn)
      if (!RESn) begin
        acc <= '0;
        oq <= 1'b0;
        dq <= '0;
      end else begin
        acc <= chg ? '0 : sat[ACC_W-1:0];
        oq <= oq | (!chg && sat != sum);
        if (fire) dq <= emit;
      end
    assign nz[i] = acc != '0;
    assign ovf[i] = oq;
    assign dout[i] = dq;
  end
  always_ff @(posedge clk or negedge RESn)
    if (!RESn) begin
      tmr <= '0;
      src_q <= 1'b0;
      rotary_inc <= 1'b0;
    end else begin
      tmr <= tc ? '0 : tmr + 1'b1;
      src_q <= src_sel;
      rotary_inc <= fire;
    end
  assign rotary_abs = 1'b0;
  assign rotary_a = dout[0];
  assign rotary_b = dout[1];
  assign overflow = ovf;
endmodule

// File: tb/tb_rotary_delta_gen.sv
// tb_rotary_delta_gen: scenario tasks plus randomized host/encoder runs against an arithmetic model
module tb_rotary_delta_gen;
  localparam int SD = 64;
  logic clk = 0, RESn = 0;
  logic [1:0] enc_a = 0, enc_b = 0, invert = 0, overflow;
  logic src_sel = 0, host_valid = 0, rotary_inc, rotary_abs;
  logic signed [8:0] host_dx = 0, host_dy = 0;
  logic signed [7:0] rotary_a, rotary_b;
  int tests = 0, fails = 0;
  int n_strobe = 0, sum_a = 0, sum_b = 0, mtmr = 0;
  int qa[$], qb[$];
  int pos[2];
  int gray[4] = '{0, 1, 3, 2};
  logic prev_inc = 0;

  rotary_delta_gen #(.SYNC_STAGES(2), .FILTER_LEN(4), .STROBE_DIV(SD), .ACC_W(12)) dut (
    .clk(clk), .RESn(RESn), .enc_a(enc_a), .enc_b(enc_b), .invert(invert), .src_sel(src_sel),
    .host_valid(host_valid), .host_dx(host_dx), .host_dy(host_dy), .rotary_inc(rotary_inc),
    .rotary_abs(rotary_abs), .rotary_a(rotary_a), .rotary_b(rotary_b), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge RESn)
    if (!RESn) mtmr <= 0;
    else mtmr <= mtmr == SD - 1 ? 0 : mtmr + 1;

  always @(negedge clk) begin
    if (rotary_inc) begin
      n_strobe++;
      sum_a += int'(rotary_a);
      sum_b += int'(rotary_b);
      qa.push_back(int'(rotary_a));
      qb.push_back(int'(rotary_b));
      tests++;
      if (prev_inc !== 1'b0) begin
        fails++;
        $display("FAIL strobe_gap: rotary_inc high two cycles in a row, required single-cycle");
      end
    end
    prev_inc = rotary_inc;
  end

  function automatic int clamp(input int v, input int lim);
    return v > lim ? lim : v < -lim ? -lim : v;
  endfunction

  task automatic do_reset(input logic s, input logic [1:0] inv);
    RESn = 0;
    src_sel = s;
    invert = inv;
    host_valid = 0;
    enc_a = 0;
    enc_b = 0;
    pos[0] = 0;
    pos[1] = 0;
    repeat (3) @(negedge clk);
    RESn = 1;
    n_strobe = 0; sum_a = 0; sum_b = 0;
    qa.delete(); qb.delete();
  endtask

  task automatic enc_step(input int ch, input int d, input int hold);
    pos[ch] = (pos[ch] + d) % 4;
    enc_a[ch] = gray[pos[ch]][1];
    enc_b[ch] = gray[pos[ch]][0];
    repeat (hold) @(negedge clk);
  endtask

  task automatic drain();
    repeat (3 * SD) @(negedge clk);
  endtask

  task automatic test_reset();
    RESn = 0;
    repeat (2) @(negedge clk);
    tests++;
    if ({rotary_inc, rotary_a, rotary_b, overflow, rotary_abs} !== 21'd0) begin
      fails++;
      $display("FAIL reset_outputs: got inc=%b a=%0d b=%0d ovf=%b abs=%b, required all 0",
               rotary_inc, rotary_a, rotary_b, overflow, rotary_abs);
    end
  endtask

  task automatic test_forward();
    do_reset(0, 2'b00);
    repeat (10) @(negedge clk);
    for (int k = 0; k < 40; k++) enc_step(0, 1, 6);
    drain();
    tests++;
    if (sum_a != 40 || sum_b != 0 || overflow !== 2'b00) begin
      fails++;
      $display("FAIL forward: sum_a=%0d sum_b=%0d ovf=%b, required 40 0 00", sum_a, sum_b, overflow);
    end
  endtask

  task automatic test_glitch();
    do_reset(0, 2'b00);
    repeat (10) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      enc_a[k % 2] = 1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      enc_a[k % 2] = 0;
      repeat (10) @(negedge clk);
    end
    host_valid = 1;
    host_dx = 9'sd100;
    @(negedge clk);
    host_valid = 0;
    drain();
    tests++;
    if (n_strobe != 0 || rotary_a !== 8'sd0) begin
      fails++;
      $display("FAIL glitch_ignored: strobes=%0d a=%0d, required 0 0", n_strobe, rotary_a);
    end
  endtask

  task automatic test_host_sat();
    do_reset(1, 2'b00);
    repeat (2) @(negedge clk);
    host_valid = 1;
    host_dx = 9'sd255;
    host_dy = 0;
    @(negedge clk);
    host_dx = 9'sd45;
    @(negedge clk);
    host_valid = 0;
    repeat (5 * SD) @(negedge clk);
    tests++;
    if (qa.size() != 3) begin
      fails++;
      $display("FAIL host_sat_count: got %0d strobes, required 3", qa.size());
    end else begin
      tests++;
      if (qa[0] != 127 || qa[1] != 127 || qa[2] != 46 || qb[0] != 0 || qb[2] != 0) begin
        fails++;
        $display("FAIL host_sat_values: a=%0d,%0d,%0d b0=%0d, required 127,127,46 0",
                 qa[0], qa[1], qa[2], qb[0]);
      end
    end
  endtask

  task automatic test_simul();
    do_reset(1, 2'b00);
    for (int k = 0; k < 2 * SD && mtmr != 10; k++) @(negedge clk);
    host_valid = 1; host_dx = 0; host_dy = -9'sd3;
    @(negedge clk);
    host_valid = 0;
    for (int k = 0; k < 2 * SD && mtmr != SD - 1; k++) @(negedge clk);
    host_valid = 1; host_dy = -9'sd5;
    @(negedge clk);
    host_valid = 0;
    drain();
    tests++;
    if (qb.size() != 2) begin
      fails++;
      $display("FAIL simul_count: got %0d strobes, required 2", qb.size());
    end else begin
      tests++;
      if (qb[0] != -3 || qb[1] != -5 || qa[0] != 0 || qa[1] != 0) begin
        fails++;
        $display("FAIL simul_values: b=%0d,%0d a=%0d,%0d, required -3,-5 0,0", qb[0], qb[1], qa[0], qa[1]);
      end
    end
  endtask

  task automatic test_illegal_invert();
    do_reset(0, 2'b10);
    repeat (10) @(negedge clk);
    enc_step(0, 2, 8);
    enc_step(0, 1, 8);
    enc_step(0, 1, 8);
    for (int k = 0; k < 8; k++) enc_step(1, 1, 7);
    drain();
    tests++;
    if (sum_a != 2) begin
      fails++;
      $display("FAIL illegal_skip: sum_a=%0d, required 2", sum_a);
    end
    tests++;
    if (sum_b != -8) begin
      fails++;
      $display("FAIL invert_b: sum_b=%0d, required -8", sum_b);
    end
  endtask

  task automatic test_async_reset();
    do_reset(1, 2'b00);
    repeat (2) @(negedge clk);
    host_valid = 1; host_dx = 9'sd177; host_dy = 0;
    @(negedge clk);
    host_valid = 0;
    for (int k = 0; k < 2 * SD && n_strobe == 0; k++) @(negedge clk);
    tests++;
    if (n_strobe != 1 || rotary_a !== 8'sd127) begin
      fails++;
      $display("FAIL pre_reset_strobe: strobes=%0d a=%0d, required 1 127", n_strobe, rotary_a);
    end
    repeat (5) @(negedge clk);
    #2 RESn = 0;
    #1;
    tests++;
    if (rotary_a !== 8'sd0 || rotary_inc !== 1'b0 || overflow !== 2'b00) begin
      fails++;
      $display("FAIL async_reset: a=%0d inc=%b ovf=%b, required 0 0 00", rotary_a, rotary_inc, overflow);
    end
    src_sel = 0;
    enc_a[0] = 0; enc_b[0] = 1;
    pos[0] = 1;
    repeat (3) @(negedge clk);
    RESn = 1;
    n_strobe = 0; sum_a = 0; sum_b = 0;
    drain();
    tests++;
    if (n_strobe != 0 || overflow !== 2'b00) begin
      fails++;
      $display("FAIL post_reset_idle: strobes=%0d ovf=%b, required 0 00", n_strobe, overflow);
    end
    enc_step(0, 1, 8);
    drain();
    tests++;
    if (n_strobe != 1 || sum_a != 1) begin
      fails++;
      $display("FAIL post_reset_step: strobes=%0d sum_a=%0d, required 1 1", n_strobe, sum_a);
    end
  endtask

  task automatic test_random_host();
    int ma[2], mov[2], ev[2], d[2];
    logic ei, v, fire;
    do_reset(1, 2'b00);
    repeat (2) @(negedge clk);
    ma = '{0, 0}; mov = '{0, 0}; ev = '{0, 0};
    ei = 0;
    for (int c = 0; c < 3000; c++) begin
      tests++;
      if (rotary_inc !== ei || int'(rotary_a) != ev[0] || int'(rotary_b) != ev[1]) begin
        fails++;
        $display("FAIL rand_host cycle %0d: inc=%b a=%0d b=%0d, required %b %0d %0d",
                 c, rotary_inc, rotary_a, rotary_b, ei, ev[0], ev[1]);
      end
      if (c >= 1000 && c < 1100) begin
        v = 1; d[0] = 255; d[1] = -256;
      end else begin
        v = $urandom_range(0, 2) == 0;
        d[0] = int'($urandom_range(0, 511)) - 256;
        d[1] = int'($urandom_range(0, 511)) - 256;
      end
      host_valid = v;
      host_dx = 9'(d[0]);
      host_dy = 9'(d[1]);
      fire = mtmr == SD - 1 && (ma[0] != 0 || ma[1] != 0);
      ei = fire;
      for (int ch = 0; ch < 2; ch++) begin
        int e, s;
        e = fire ? clamp(ma[ch], 127) : 0;
        s = ma[ch] - e + (v ? d[ch] : 0);
        if (s != clamp(s, 2047)) mov[ch] = 1;
        ma[ch] = clamp(s, 2047);
        if (fire) ev[ch] = e;
      end
      @(negedge clk);
    end
    host_valid = 0;
    tests++;
    if (overflow !== {mov[1] != 0, mov[0] != 0}) begin
      fails++;
      $display("FAIL rand_overflow: got %b, required %b%b", overflow, mov[1] != 0, mov[0] != 0);
    end
  endtask

  task automatic test_random_enc();
    int net[2], d, ch;
    logic [1:0] inv;
    inv = 2'($urandom_range(0, 3));
    do_reset(0, inv);
    repeat (10) @(negedge clk);
    net = '{0, 0};
    for (int k = 0; k < 80; k++) begin
      ch = $urandom_range(0, 1);
      d = $urandom_range(0, 5) == 0 ? 2 : $urandom_range(0, 2) == 0 ? 3 : 1;
      if (d != 2) net[ch] += (d == 1 ? 1 : -1) * (inv[ch] ? -1 : 1);
      enc_step(ch, d, $urandom_range(5, 9));
    end
    drain();
    tests++;
    if (sum_a != net[0] || sum_b != net[1]) begin
      fails++;
      $display("FAIL rand_enc: sum_a=%0d sum_b=%0d, required %0d %0d (inv=%b)",
               sum_a, sum_b, net[0], net[1], inv);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_glitch();
    test_host_sat();
    test_simul();
    test_illegal_invert();
    test_async_reset();
    test_random_host();
    test_random_enc();
    test_random_enc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
